// File: rtl/btod_sequencer_pkg.sv
// rtl/btod_sequencer_pkg.sv - shared types and defaults for btod_sequencer
package btodSeq_package;

    typedef logic [7:0] dSt;

    typedef enum logic [1:0] {
        IDLE,
        START,
        ISSUE,
        GAP
    } btodSeqStateT;

    localparam int BTOD_BURST_MAX_DEF  = 8;
    localparam int BTOD_FIFO_DEPTH_DEF = 4;

    typedef logic [7:0]  burstCntT;
    typedef logic [15:0] issuedCntT;

endpackage

// File: rtl/btod_sequencer_if.sv
// rtl/btod_sequencer_if.sv - handshake interfaces used by btod_sequencer
interface rdy_vld_if #(parameter type data_t = btodSeq_package::dSt);
    logic  vld;
    logic  rdy;
    data_t data;

    modport src (output vld, output data, input rdy);
    modport dst (input vld, input data, output rdy);
endinterface

interface req_ack_if #(parameter type data_t = btodSeq_package::dSt);
    logic  req;
    logic  ack;
    data_t data;

    modport src (output req, output data, input ack);
    modport dst (input req, input data, output ack);
endinterface

interface notify_ack_if;
    logic notify;
    logic ack;

    modport src (output notify, input ack);
    modport dst (input notify, output ack);
endinterface

// File: rtl/btod_sequencer_fifo.sv
// rtl/btod_sequencer_fifo.sv - synchronous command FIFO, registered head, no fall-through
module fifo_sync #(
    parameter type data_t = btodSeq_package::dSt,
    parameter int  DEPTH  = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  data_t wdata,
    output data_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    data_t         mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses the push even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/btod_sequencer.sv
// rtl/btod_sequencer.sv - buffers commands and issues them to blockB in notified bursts
module btod_sequencer
    import btodSeq_package::*;
#(
    parameter type data_t     = dSt,
    parameter int  FIFO_DEPTH = BTOD_FIFO_DEPTH_DEF,
    parameter int  BURST_MAX  = BTOD_BURST_MAX_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    rdy_vld_if.dst    cmdIn,
    req_ack_if.src    btod,
    notify_ack_if.src startDone,
    output logic      busy,
    output issuedCntT issuedCnt
);

    localparam burstCntT BURST_LIMIT = burstCntT'(BURST_MAX);

    btodSeqStateT state, state_nxt;
    burstCntT     burst_cnt, burst_cnt_nxt;
    issuedCntT    issued_cnt, issued_cnt_nxt;
    data_t        data_q, data_nxt;

    logic  fifo_full;
    logic  fifo_empty;
    logic  fifo_pop;
    data_t fifo_rdata;

    fifo_sync #(
        .data_t (data_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmdIn.vld),
        .pop   (fifo_pop),
        .wdata (cmdIn.data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt      = state;
        burst_cnt_nxt  = burst_cnt;
        issued_cnt_nxt = issued_cnt;
        data_nxt       = data_q;
        fifo_pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    burst_cnt_nxt = '0;
                    state_nxt     = START;
                end
            end
            START: begin
                if (startDone.ack) begin
                    data_nxt  = fifo_rdata;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (btod.ack) begin
                    fifo_pop       = 1'b1;
                    burst_cnt_nxt  = burst_cnt + burstCntT'(1);
                    issued_cnt_nxt = issued_cnt + issuedCntT'(1);
                    state_nxt      = GAP;
                end
            end
            GAP: begin
                // fifo_empty already reflects the pop taken on the ack edge
                if (burst_cnt == BURST_LIMIT || fifo_empty) begin
                    state_nxt = IDLE;
                end else begin
                    data_nxt  = fifo_rdata;
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            issued_cnt <= '0;
            data_q     <= '0;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_cnt_nxt;
            issued_cnt <= issued_cnt_nxt;
            data_q     <= data_nxt;
        end
    end

    assign cmdIn.rdy        = !fifo_full;
    assign btod.req         = (state == ISSUE);
    assign btod.data        = data_q;
    assign startDone.notify = (state == START);
    assign busy             = (state != IDLE);
    assign issuedCnt        = issued_cnt;

endmodule
